// File: rtl/volume_pkg.sv
// Shared constants and types for the volume / mute icon control slice.
// Holds the mode encoding and the default volume width and reset level.
package volume_pkg;

    localparam int LEVEL_W       = 3;
    localparam int DEFAULT_LEVEL = 4;

    typedef logic [LEVEL_W-1:0] volume_level_t;

    localparam logic MODE_MUTED = 1'b0;
    localparam logic MODE_ON    = 1'b1;

endpackage : volume_pkg

// File: rtl/key_debounce.sv
// Key debouncer: 2-FF synchronizer, stability counter, and a single-clock press
// pulse on the accepted 0->1 transition. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic resetN,
    input  logic keyRaw,
    output logic keyStable,
    output logic pressPulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q,   sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             pulse_q,  pulse_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d   = {sync_q[0], keyRaw};
        stable_d = stable_q;
        count_d  = '0;
        pulse_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (count_q == CNT_LAST) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1];
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            count_q  <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            pulse_q  <= pulse_d;
        end
    end

    assign keyStable  = stable_q;
    assign pressPulse = pulse_q;

endmodule : key_debounce

// File: rtl/volume_mode_ctrl.sv
// Mute/volume control upstream of the volume icon: debounced keys, frame-synchronous
// mode update, saturating volume level. Optional VOLUME_AUTO_UNMUTE_EN: volume-up unmutes.
module volume_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
    parameter int          LEVEL_W         = volume_pkg::LEVEL_W,
    parameter int          DEFAULT_LEVEL   = volume_pkg::DEFAULT_LEVEL
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               toggleKeyRaw,
    input  logic               volUpKeyRaw,
    input  logic               volDownKeyRaw,
    input  logic               startOfFrame,
    output logic               mode,
    output logic               soundEnable,
    output logic [LEVEL_W-1:0] volumeLevel,
    output logic               levelChanged
);

    import volume_pkg::*;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX   = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_RESET = LEVEL_W'(DEFAULT_LEVEL);

    logic [2:0] key_stable_unused;
    logic       toggle_pulse;
    logic       up_pulse;
    logic       down_pulse;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_toggle_db (
        .clk        (clk),
        .resetN     (resetN),
        .keyRaw     (toggleKeyRaw),
        .keyStable  (key_stable_unused[0]),
        .pressPulse (toggle_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk        (clk),
        .resetN     (resetN),
        .keyRaw     (volUpKeyRaw),
        .keyStable  (key_stable_unused[1]),
        .pressPulse (up_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
        .clk        (clk),
        .resetN     (resetN),
        .keyRaw     (volDownKeyRaw),
        .keyStable  (key_stable_unused[2]),
        .pressPulse (down_pulse)
    );

    logic               mode_q,           mode_d;
    logic               pending_toggle_q, pending_toggle_d;
    logic [LEVEL_W-1:0] level_q,          level_d;
    logic               level_changed_q,  level_changed_d;
    logic               pending_next;

    always_comb begin
        // A press landing on the frame pulse is folded into that frame's update.
        pending_next = pending_toggle_q ^ toggle_pulse;
`ifdef VOLUME_AUTO_UNMUTE_EN
        if (up_pulse && (mode_q == MODE_MUTED)) begin
            pending_next = 1'b1;
        end
`endif
        mode_d           = mode_q;
        pending_toggle_d = pending_next;
        if (startOfFrame) begin
            mode_d           = mode_q ^ pending_next;
            pending_toggle_d = 1'b0;
        end

        level_d         = level_q;
        level_changed_d = 1'b0;
        if (up_pulse && !down_pulse && (level_q != LEVEL_MAX)) begin
            level_d         = level_q + 1'b1;
            level_changed_d = 1'b1;
        end else if (down_pulse && !up_pulse && (level_q != '0)) begin
            level_d         = level_q - 1'b1;
            level_changed_d = 1'b1;
        end
    end

    // NOTE: only control flops exist here, so every one is reset; there is no memory to leave unreset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mode_q           <= MODE_ON;
            pending_toggle_q <= 1'b0;
            level_q          <= LEVEL_RESET;
            level_changed_q  <= 1'b0;
        end else begin
            mode_q           <= mode_d;
            pending_toggle_q <= pending_toggle_d;
            level_q          <= level_d;
            level_changed_q  <= level_changed_d;
        end
    end

    assign mode         = mode_q;
    assign soundEnable  = mode_q;
    assign volumeLevel  = level_q;
    assign levelChanged = level_changed_q;

endmodule : volume_mode_ctrl
